// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, widths and bridge state type for the CPU-to-AHB
// master bridge.
package ahb_pkg;

  localparam int AHB_ADDR_W  = 32;
  localparam int AHB_DATA_W  = 32;
  localparam int AHB_TRANS_W = 2;
  localparam int AHB_SIZE_W  = 3;
  localparam int AHB_RESP_W  = 2;

  typedef enum logic [AHB_TRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [AHB_RESP_W-1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [AHB_SIZE_W-1:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } bridge_state_e;

  // Sizes wider than a word are rejected along with misaligned half/word accesses.
  function automatic logic bad_access(input logic [AHB_SIZE_W-1:0] size,
                                      input logic [1:0] addr_lo);
    return (size > HSIZE_WORD) ||
           (size == HSIZE_HALF && addr_lo[0]) ||
           (size == HSIZE_WORD && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/ahb_master_bridge.sv
// Single-transfer CPU request port to one arbitrated AHB-Lite master port.
// Retries on RETRY/SPLIT up to MAX_RETRY times, reports ERROR to the CPU.
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter int          ADDR_W    = AHB_ADDR_W,
  parameter int          DATA_W    = AHB_DATA_W,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [AHB_SIZE_W-1:0]  cpu_size,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_busy,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   HBUSREQ,
  output logic                   HLOCK,
  input  logic                   HGRANT,
  output logic [AHB_TRANS_W-1:0] HTRANS,
  output logic [ADDR_W-1:0]      HADDR,
  output logic                   HWRITE,
  output logic [AHB_SIZE_W-1:0]  HSIZE,
  output logic [DATA_W-1:0]      HWDATA,
  input  logic                   HREADY,
  input  logic [AHB_RESP_W-1:0]  HRESP,
  input  logic [DATA_W-1:0]      HRDATA
);

  localparam logic [4:0] MAX_RETRY_C = 5'(MAX_RETRY);

  bridge_state_e          state_q, state_d;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [AHB_SIZE_W-1:0]  size_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [3:0]             retry_cnt_q;
  logic                   err_q;
  logic [4:0]             retry_nxt;
  logic                   retry_exhausted;
  logic                   req_bad;

  // One extra bit so the count past MAX_RETRY=15 is still visible.
  assign retry_nxt       = {1'b0, retry_cnt_q} + 5'd1;
  assign retry_exhausted = (retry_nxt > MAX_RETRY_C);
  assign req_bad         = bad_access(cpu_size, cpu_addr[1:0]);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cpu_req) state_d = req_bad ? ST_DONE : ST_REQ;
      ST_REQ:  if (HGRANT && HREADY) state_d = ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: begin
        if (HREADY) begin
          if (HRESP == HRESP_OKAY || HRESP == HRESP_ERROR) state_d = ST_DONE;
          else state_d = retry_exhausted ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      retry_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && cpu_req) begin
        we_q        <= cpu_we;
        addr_q      <= cpu_addr;
        size_q      <= cpu_size;
        wdata_q     <= cpu_wdata;
        retry_cnt_q <= '0;
        err_q       <= req_bad;
      end
      if (state_q == ST_DATA && HREADY) begin
        unique case (HRESP)
          HRESP_OKAY: begin
            err_q <= 1'b0;
            if (!we_q) rdata_q <= HRDATA;
          end
          HRESP_ERROR: err_q <= 1'b1;
          default: begin
            retry_cnt_q <= retry_nxt[3:0];
            if (retry_exhausted) err_q <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    cpu_busy  = (state_q != ST_IDLE);
    cpu_ready = (state_q == ST_DONE);
    cpu_err   = (state_q == ST_DONE) && err_q;
    HBUSREQ   = (state_q == ST_REQ) || (state_q == ST_ADDR);
    HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  assign HLOCK     = 1'b0;
  assign HADDR     = addr_q;
  assign HWRITE    = we_q;
  assign HSIZE     = size_q;
  assign HWDATA    = wdata_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Directed bench for ahb_master_bridge: cycle vectors for single transfers plus
// a reactive slave/arbiter task for wait-state, grant, retry and error cases.
module tb_ahb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_size;
  logic        cpu_busy, cpu_ready, cpu_err;
  logic [31:0] cpu_rdata;
  logic        HBUSREQ, HLOCK, HGRANT, HWRITE, HREADY;
  logic [1:0]  HTRANS, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    logic        req, we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic        gnt, rdy;
    logic [31:0] hrd;
    logic        e_busy, e_busreq;
    logic [1:0]  e_trans;
    logic        e_ready, e_err, e_chkwd;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic [2:0] size,
                              logic [31:0] wd, logic gnt, logic rdy, logic [31:0] hrd,
                              logic e_busy, logic e_busreq, logic [1:0] e_trans,
                              logic e_ready, logic e_err, logic e_chkwd, logic [31:0] e_rdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.size = size; v.wd = wd;
    v.gnt = gnt; v.rdy = rdy; v.hrd = hrd;
    v.e_busy = e_busy; v.e_busreq = e_busreq; v.e_trans = e_trans;
    v.e_ready = e_ready; v.e_err = e_err; v.e_chkwd = e_chkwd; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Plays arbiter and slave: grant held low for grant_lo cycles after the request,
  // data phases either OKAY after `waits` wait states, or a two-cycle RETRY/ERROR
  // for the first n_retry attempts (every attempt when err_resp).
  task automatic run_slave(input logic [31:0] exp_addr, input int grant_lo, input int waits,
                           input int n_retry, input logic err_resp, input logic [31:0] rd,
                           output int n_ns, output int first_ns, output int lat,
                           output int rises, output int viol, output logic got_err,
                           output logic [31:0] got_rdata, output logic addr_ok);
    int dp, att;
    logic prev_ns, prev_busreq, special, done;
    dp = 0; att = 0; prev_ns = 1'b0; prev_busreq = 1'b0; done = 1'b0;
    n_ns = 0; first_ns = 0; lat = 0; rises = 0; viol = 0;
    got_err = 1'b0; got_rdata = '0; addr_ok = 1'b1;
    HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'd0; HRDATA = '1;
    for (int c = 1; c <= 80 && !done; c++) begin
      step();
      cpu_req = 1'b0;
      if (cpu_ready) begin
        done = 1'b1; lat = c; got_err = cpu_err; got_rdata = cpu_rdata;
      end else begin
        if (HBUSREQ && !prev_busreq) rises++;
        prev_busreq = HBUSREQ;
        if (c >= 2 && c <= grant_lo + 1 && (HBUSREQ !== 1'b1 || HTRANS !== 2'b00)) viol++;
        if (HTRANS == 2'b10) begin
          n_ns++;
          if (first_ns == 0) first_ns = c;
          if (HADDR !== exp_addr) addr_ok = 1'b0;
        end
        if (prev_ns) dp = 1;
        else if (dp > 0 && HREADY) dp = 0;
        else if (dp > 0) dp++;
        if (dp > 0 && HTRANS !== 2'b00) viol++;
        prev_ns = (HTRANS == 2'b10);
        HGRANT = (c > grant_lo);
        special = err_resp || (att < n_retry);
        if (dp == 0) begin
          HREADY = 1'b1; HRESP = 2'd0; HRDATA = '1;
        end else if (special) begin
          HREADY = (dp == 2); HRESP = err_resp ? 2'd1 : 2'd2; HRDATA = '1;
          if (dp == 2) att++;
        end else begin
          HREADY = (dp > waits); HRESP = 2'd0; HRDATA = rd;
        end
      end
    end
    HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'd0;
    step();
  endtask

  vec_t vecs[24];

  initial begin
    int n_ns, first_ns, lat, rises, viol;
    logic got_err, addr_ok;
    logic [31:0] got_rd;

    vecs[0]  = mk(1,1,32'h1000_0004,2,32'hDEAD_BEEF, 1,1,0, 1,1,2'd0,0,0,0, 32'h0);
    vecs[1]  = mk(0,1,32'h1000_0004,2,32'hDEAD_BEEF, 1,1,0, 1,1,2'd2,0,0,0, 32'h0);
    vecs[2]  = mk(0,1,32'h1000_0004,2,32'hDEAD_BEEF, 1,1,0, 1,0,2'd0,0,0,1, 32'h0);
    vecs[3]  = mk(0,1,32'h1000_0004,2,32'hDEAD_BEEF, 1,1,0, 1,0,2'd0,1,0,0, 32'h0);
    vecs[4]  = mk(0,1,32'h1000_0004,2,32'hDEAD_BEEF, 1,1,0, 0,0,2'd0,0,0,0, 32'h0);
    vecs[5]  = mk(1,0,32'h2000_0002,2,32'h0,         1,1,0, 1,0,2'd0,1,1,0, 32'h0);
    vecs[6]  = mk(0,0,32'h2000_0002,2,32'h0,         1,1,0, 0,0,2'd0,0,0,0, 32'h0);
    vecs[7]  = mk(1,0,32'h2000_0001,1,32'h0,         1,1,0, 1,0,2'd0,1,1,0, 32'h0);
    vecs[8]  = mk(0,0,32'h2000_0001,1,32'h0,         1,1,0, 0,0,2'd0,0,0,0, 32'h0);
    vecs[9]  = mk(1,0,32'h2000_0000,3,32'h0,         1,1,0, 1,0,2'd0,1,1,0, 32'h0);
    vecs[10] = mk(0,0,32'h2000_0000,3,32'h0,         1,1,0, 0,0,2'd0,0,0,0, 32'h0);
    vecs[11] = mk(1,0,32'h3000_0002,1,32'h0,         1,1,0, 1,1,2'd0,0,0,0, 32'h0);
    vecs[12] = mk(0,0,32'h3000_0002,1,32'h0,         1,0,0, 1,1,2'd0,0,0,0, 32'h0);
    vecs[13] = mk(0,0,32'h3000_0002,1,32'h0,         1,1,0, 1,1,2'd2,0,0,0, 32'h0);
    vecs[14] = mk(0,0,32'h3000_0002,1,32'h0,         1,0,0, 1,1,2'd2,0,0,0, 32'h0);
    vecs[15] = mk(0,0,32'h3000_0002,1,32'h0,         1,1,0, 1,0,2'd0,0,0,0, 32'h0);
    vecs[16] = mk(0,0,32'h3000_0002,1,32'h0,         1,1,32'hCAFE_F00D, 1,0,2'd0,1,0,0, 32'hCAFE_F00D);
    vecs[17] = mk(1,0,32'h3000_0002,1,32'h0,         1,1,0, 0,0,2'd0,0,0,0, 32'hCAFE_F00D);
    vecs[18] = mk(0,0,32'h3000_0002,1,32'h0,         1,1,0, 0,0,2'd0,0,0,0, 32'hCAFE_F00D);
    vecs[19] = mk(1,1,32'h4000_0003,0,32'h0000_00A5, 1,1,0, 1,1,2'd0,0,0,0, 32'hCAFE_F00D);
    vecs[20] = mk(0,1,32'h4000_0003,0,32'h0000_00A5, 1,1,0, 1,1,2'd2,0,0,0, 32'hCAFE_F00D);
    vecs[21] = mk(0,1,32'h4000_0003,0,32'h0000_00A5, 1,1,0, 1,0,2'd0,0,0,1, 32'hCAFE_F00D);
    vecs[22] = mk(0,1,32'h4000_0003,0,32'h0000_00A5, 1,1,0, 1,0,2'd0,1,0,0, 32'hCAFE_F00D);
    vecs[23] = mk(0,1,32'h4000_0003,0,32'h0000_00A5, 1,1,0, 0,0,2'd0,0,0,0, 32'hCAFE_F00D);

    HRESET = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_size = '0; cpu_wdata = '0;
    HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'd0; HRDATA = '0;
    #12;
    chk("rst_ctl", 32'({cpu_busy, cpu_ready, cpu_err, HBUSREQ, HLOCK, HTRANS, HWRITE, HSIZE}), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      cpu_size = vecs[i].size; cpu_wdata = vecs[i].wd;
      HGRANT = vecs[i].gnt; HREADY = vecs[i].rdy; HRESP = 2'd0; HRDATA = vecs[i].hrd;
      step();
      chk($sformatf("v%0d_busy", i), 32'(cpu_busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_busreq", i), 32'(HBUSREQ), 32'(vecs[i].e_busreq));
      chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(vecs[i].e_trans));
      chk($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_err", i), 32'(cpu_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_hlock", i), 32'(HLOCK), 32'h0);
      if (vecs[i].e_trans == 2'd2) begin
        chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].addr);
        chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].we));
        chk($sformatf("v%0d_hsize", i), 32'(HSIZE), 32'(vecs[i].size));
      end
      if (vecs[i].e_chkwd) chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].wd);
    end
    cpu_req = 1'b0;

    // Read with three wait states.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h2000_0000; cpu_size = 3'd2; cpu_wdata = '0;
    run_slave(32'h2000_0000, 0, 3, 0, 1'b0, 32'h1234_5678,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("ws_nonseq", n_ns, 1);
    chk("ws_latency", lat, 7);
    chk("ws_err", 32'(got_err), 0);
    chk("ws_rdata", got_rd, 32'h1234_5678);
    chk("ws_viol", viol, 0);

    // Grant withheld for five cycles.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h6000_0000; cpu_wdata = 32'h0F0F_0F0F;
    run_slave(32'h6000_0000, 5, 0, 0, 1'b0, 32'h0,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("gnt_viol", viol, 0);
    chk("gnt_first_nonseq", first_ns, 7);
    chk("gnt_latency", lat, 9);
    chk("gnt_rdata_hold", got_rd, 32'h1234_5678);

    // One RETRY then OKAY.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7000_0010;
    run_slave(32'h7000_0010, 0, 0, 1, 1'b0, 32'h5A5A_5A5A,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("rty_nonseq", n_ns, 2);
    chk("rty_busreq_rises", rises, 2);
    chk("rty_addr_same", 32'(addr_ok), 1);
    chk("rty_viol", viol, 0);
    chk("rty_latency", lat, 8);
    chk("rty_err", 32'(got_err), 0);
    chk("rty_rdata", got_rd, 32'h5A5A_5A5A);

    // ERROR response.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7000_0020;
    run_slave(32'h7000_0020, 0, 0, 0, 1'b1, 32'h0,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("err_nonseq", n_ns, 1);
    chk("err_latency", lat, 5);
    chk("err_flag", 32'(got_err), 1);
    chk("err_rdata_hold", got_rd, 32'h5A5A_5A5A);

    // Slave that always retries: MAX_RETRY=2 allows three attempts.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7000_0030;
    run_slave(32'h7000_0030, 0, 0, 99, 1'b0, 32'h0,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("maxr_nonseq", n_ns, 3);
    chk("maxr_addr_same", 32'(addr_ok), 1);
    chk("maxr_latency", lat, 13);
    chk("maxr_err", 32'(got_err), 1);
    chk("maxr_rdata_hold", got_rd, 32'h5A5A_5A5A);

    // Reset in the data phase drops the transfer.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h5000_0000; cpu_size = 3'd2; cpu_wdata = 32'h1111_1111;
    HGRANT = 1; HREADY = 1; HRESP = 2'd0;
    step();
    cpu_req = 0;
    step();
    step();
    chk("prerst_hwdata", HWDATA, 32'h1111_1111);
    chk("prerst_busy", 32'(cpu_busy), 1);
    #2 HRESET = 1'b1;
    #1;
    chk("mrst_ctl", 32'({cpu_busy, cpu_ready, cpu_err, HBUSREQ, HLOCK, HTRANS, HWRITE, HSIZE}), 32'h0);
    chk("mrst_haddr", HADDR, 32'h0);
    chk("mrst_hwdata", HWDATA, 32'h0);
    chk("mrst_rdata", cpu_rdata, 32'h0);
    step();
    #3 HRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postrst_ready%0d", k), 32'(cpu_ready), 0);
      chk($sformatf("postrst_busy%0d", k), 32'(cpu_busy), 0);
    end

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8000_0004; cpu_size = 3'd2;
    run_slave(32'h8000_0004, 0, 0, 0, 1'b0, 32'hA1B2_C3D4,
              n_ns, first_ns, lat, rises, viol, got_err, got_rd, addr_ok);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_rdata", got_rd, 32'hA1B2_C3D4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
